// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared encodings and default latencies for the mult/div
//                issue controller and its neighbours.
//  Revision    : 1.0  initial release
// ============================================================================
package md_pkg;

    // E-stage HI/LO-class operation encodings
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    // Operation codes presented to the mult/div datapath
    typedef enum logic [1:0] {
        DP_MULT  = 2'd0,
        DP_MULTU = 2'd1,
        DP_DIV   = 2'd2,
        DP_DIVU  = 2'd3
    } dp_op_t;

    localparam int MD_MUL_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF = 10;
    localparam int MD_CNT_W_DEF   = 4;

    // True for the four ops that occupy the datapath
    function automatic logic is_md_op(input logic [2:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // mult..divu are contiguous, so the datapath code is simply op-1
    function automatic dp_op_t to_dp_op(input logic [2:0] op);
        logic [2:0] w_t;
        w_t = op - 3'd1;
        return dp_op_t'(w_t[1:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl_if
//  Description : Pipeline-side bundle between the E/D stages and the mult/div
//                issue controller.
//                master : pipeline (drives op/valid/flush/b_zero/md_use_d)
//                slave  : controller (drives start/dp_op/busy/stall/writes)
//  Revision    : 1.0  initial release
// ============================================================================
interface md_issue_ctrl_if #(
    parameter int CNT_W = 4
);
    logic [2:0]       md_op_e;
    logic             e_valid;
    logic             flush;
    logic             b_zero;
    logic             md_use_d;
    logic             start;
    logic [1:0]       dp_op;
    logic             busy;
    logic             stall;
    logic             hilo_we;
    logic             hi_we;
    logic             lo_we;
    logic             dz;
    logic [CNT_W-1:0] cnt;

    modport master (
        output md_op_e, e_valid, flush, b_zero, md_use_d,
        input  start, dp_op, busy, stall, hilo_we, hi_we, lo_we, dz, cnt
    );

    modport slave (
        input  md_op_e, e_valid, flush, b_zero, md_use_d,
        output start, dp_op, busy, stall, hilo_we, hi_we, lo_we, dz, cnt
    );
endinterface
`default_nettype wire

// File: rtl/md_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_lat_counter
//  Description : Loadable down-counter tracking remaining operation cycles.
//                Ports: clk, reset (async, active-low), load_i/load_val_i,
//                dec_i, cnt_o (current count), zero_o (count == 0).
//  Revision    : 1.0  initial release
// ============================================================================
module md_lat_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_val_i,
    input  wire logic             dec_i,
    output logic      [CNT_W-1:0] cnt_o,
    output logic                  zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : md_issue_ctrl
//  Description : Issue/sequencing controller for the mult/div unit and HI/LO.
//                Fires a start pulse on acceptance, counts the fixed latency,
//                pulses the HI/LO commit (or dz on divide by zero) and stalls
//                D-stage HI/LO users while the unit is occupied.
//                Ports: clk, reset (async, active-low), io (slave modport:
//                E/D-stage inputs in; start/dp_op/busy/stall/hilo_we/hi_we/
//                lo_we/dz/cnt out).
//  Revision    : 1.0  initial release
// ============================================================================
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT_DEF,
    parameter int DIV_LAT = MD_DIV_LAT_DEF,
    parameter int CNT_W   = MD_CNT_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    md_issue_ctrl_if.slave  io
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // The counter is loaded with LAT-1 because the final (cnt==0) RUN cycle
    // is itself the commit cycle.
    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       dp_op_q, dp_op_d;
    logic             zero_q,  zero_d;

    logic             w_idle;
    logic             w_run;
    logic             w_e_live;
    logic             w_accept;
    logic             w_is_div;
    logic             w_done;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_load_val;

    assign w_idle   = (state_q == S_IDLE);
    assign w_run    = (state_q == S_RUN);
    // flush and occupancy gate everything coming from E; ops arriving
    // while RUN are silently dropped.
    assign w_e_live = io.e_valid & ~io.flush & w_idle;
    assign w_accept = w_e_live & is_md_op(io.md_op_e);
    assign w_is_div = (io.md_op_e == MD_DIV) || (io.md_op_e == MD_DIVU);
    assign w_done   = w_run & w_cnt_zero;
    assign w_load_val = w_is_div ? c_div_load : c_mul_load;

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_accept),
        .load_val_i (w_load_val),
        .dec_i      (w_run & ~w_cnt_zero),
        .cnt_o      (w_cnt),
        .zero_o     (w_cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        dp_op_d = dp_op_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d = S_RUN;
                    dp_op_d = to_dp_op(io.md_op_e);
                    zero_d  = io.b_zero & w_is_div;
                end
            end
            S_RUN: begin
                if (w_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            dp_op_q <= 2'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dp_op_q <= dp_op_d;
            zero_q  <= zero_d;
        end
    end

    assign io.start   = w_accept;
    // Present the new op combinationally alongside start, then hold it.
    assign io.dp_op   = w_accept ? to_dp_op(io.md_op_e) : dp_op_q;
    assign io.busy    = w_run;
    assign io.stall   = io.md_use_d & (w_accept | w_run);
    assign io.hilo_we = w_done & ~zero_q;
    assign io.dz      = w_done & zero_q;
    assign io.hi_we   = w_e_live & (io.md_op_e == MD_MTHI);
    assign io.lo_we   = w_e_live & (io.md_op_e == MD_MTLO);
    assign io.cnt     = w_cnt;
endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md_issue_ctrl
//  Description : Self-checking bench for md_issue_ctrl. A timeline model
//                (accept cycle + latency) predicts every output each cycle;
//                directed scenarios add literal timing expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int CNT_W = 4;
    localparam int MLAT  = 5;
    localparam int DLAT  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    md_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    md_issue_ctrl #(
        .MUL_LAT (MLAT),
        .DIV_LAT (DLAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model + per-cycle compare ----------------
    int   cyc = 0;
    bit   m_active = 0;
    int   m_tacc = 0;
    int   m_lat = 0;
    bit   m_z = 0;
    int   m_dpop = 0;
    int   last_start = -1;
    int   last_hilo = -1;
    int   last_dz = -1;
    int   n_hilo = 0;
    int   n_dz = 0;
    int   n_stall = 0;

    initial begin
        forever begin
            bit e_busy, e_done, e_gate, e_acc;
            int op, e_cnt, e_dpop;
            @(negedge clk);
            op = int'(bus.md_op_e);
            if (!reset) begin
                m_active = 0;
                m_dpop   = 0;
                chk("rst_start", bus.start, 0);
                chk("rst_busy",  bus.busy, 0);
                chk("rst_stall", bus.stall, 0);
                chk("rst_hilo",  bus.hilo_we, 0);
                chk("rst_dz",    bus.dz, 0);
                chk("rst_hiwe",  bus.hi_we, 0);
                chk("rst_lowe",  bus.lo_we, 0);
                chk("rst_cnt",   bus.cnt, 0);
                chk("rst_dpop",  bus.dp_op, 0);
            end else begin
                e_busy = m_active && (cyc > m_tacc) && (cyc <= m_tacc + m_lat);
                e_done = e_busy && (cyc == m_tacc + m_lat);
                e_gate = bus.e_valid && !bus.flush && !e_busy;
                e_acc  = e_gate && (op >= 1) && (op <= 4);
                e_cnt  = e_busy ? (m_tacc + m_lat - cyc) : 0;
                e_dpop = e_acc ? (op - 1) : m_dpop;
                chk("start",   bus.start, e_acc);
                chk("busy",    bus.busy, e_busy);
                chk("stall",   bus.stall, bus.md_use_d && (e_acc || e_busy));
                chk("hilo_we", bus.hilo_we, e_done && !m_z);
                chk("dz",      bus.dz, e_done && m_z);
                chk("hi_we",   bus.hi_we, e_gate && (op == 5));
                chk("lo_we",   bus.lo_we, e_gate && (op == 6));
                chk("cnt",     bus.cnt, e_cnt);
                chk("dp_op",   bus.dp_op, e_dpop);
                if (e_done) m_active = 0;
                if (e_acc) begin
                    m_active = 1;
                    m_tacc   = cyc;
                    m_lat    = (op >= 3) ? DLAT : MLAT;
                    m_z      = bus.b_zero && (op >= 3);
                    m_dpop   = op - 1;
                end
            end
            if (bus.start)   last_start = cyc;
            if (bus.hilo_we) begin last_hilo = cyc; n_hilo++; end
            if (bus.dz)      begin last_dz = cyc; n_dz++; end
            if (bus.stall)   n_stall++;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] op, input logic v, input logic f,
                         input logic bz, input logic ud);
        @(posedge clk);
        #1;
        bus.md_op_e = op;
        bus.e_valid = v;
        bus.flush   = f;
        bus.b_zero  = bz;
        bus.md_use_d = ud;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int t_a, h0, s0, d0;
        bus.md_op_e = MD_NONE;
        bus.e_valid = 1'b0;
        bus.flush   = 1'b0;
        bus.b_zero  = 1'b0;
        bus.md_use_d = 1'b0;

        // reset
        idle(3);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("lit_reset_busy", bus.busy, 0);
        chk("lit_reset_cnt",  bus.cnt, 0);
        idle(2);

        // mult with mfhi waiting in D
        s0 = n_stall;
        drive(MD_MULT, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        chk("lit_mult_start", bus.start, 1);
        chk("lit_mult_stall", bus.stall, 1);
        for (int i = 0; i < MLAT; i++) drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("lit_mult_stall_drop", bus.stall, 0);
        chk("lit_mult_busy_drop",  bus.busy, 0);
        chk("lit_mult_hilo_lat",   last_hilo - last_start, 5);
        chk("lit_mult_stall_cyc",  n_stall - s0, 6);
        idle(1);

        // divu by zero
        h0 = n_hilo;
        d0 = n_dz;
        drive(MD_DIVU, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        chk("lit_divu_dpop", bus.dp_op, 3);
        idle(DLAT + 1);
        chk("lit_dz_lat",   last_dz - last_start, 10);
        chk("lit_dz_count", n_dz - d0, 1);
        chk("lit_dz_nohilo", n_hilo - h0, 0);

        // back-to-back mult then div
        drive(MD_MULT, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < MLAT; i++) drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        t_a = last_start;
        drive(MD_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("lit_b2b_start", bus.start, 1);
        chk("lit_b2b_busy",  bus.busy, 0);
        idle(DLAT + 1);
        chk("lit_b2b_spacing", last_start - t_a, 6);
        chk("lit_b2b_hilo",    last_hilo - t_a, 16);

        // mthi / mtlo with and without flush
        drive(MD_MTHI, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 chk("lit_mthi_flush", bus.hi_we, 0);
        drive(MD_MTHI, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("lit_mthi_we",    bus.hi_we, 1);
        chk("lit_mthi_stall", bus.stall, 0);
        chk("lit_mthi_busy",  bus.busy, 0);
        drive(MD_MTLO, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 chk("lit_mtlo_we", bus.lo_we, 1);

        // div flushed at accept, then div flushed during RUN
        drive(MD_DIV, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 chk("lit_divflush_start", bus.start, 0);
        drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 chk("lit_divflush_busy", bus.busy, 0);
        drive(MD_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        t_a = cyc;
        for (int i = 0; i < DLAT; i++) drive(MD_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("lit_runflush_hilo", last_hilo - t_a, 10);

        // op arriving while RUN is ignored; reserved op is a no-op
        drive(MD_MULTU, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(MD_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        chk("lit_ignore_start", bus.start, 0);
        chk("lit_ignore_dpop",  bus.dp_op, 1);
        idle(MLAT);
        drive(MD_RSVD, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        chk("lit_rsvd_start", bus.start, 0);
        chk("lit_rsvd_stall", bus.stall, 0);

        // reset mid-run
        h0 = n_hilo;
        drive(MD_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        drive(MD_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("lit_midrst_busy", bus.busy, 0);
        chk("lit_midrst_cnt",  bus.cnt, 0);
        idle(1);
        @(posedge clk); #1 reset = 1'b1;
        idle(5);
        chk("lit_midrst_nohilo", n_hilo - h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
